mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_pkg.sv | 22 ++
 rtl/mips_cpu_muldiv_if.sv | 14 +
 rtl/mips_cpu_divider.sv | 60 ++++++
 rtl/mips_cpu_muldiv.sv | 154 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS HI/LO multiply-divide unit: op encoding,
// iteration count and a magnitude helper used by the multiply and divide paths.
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

    // Absolute value when the operand is treated as signed; 0x80000000 stays 0x80000000.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide unit.
interface mips_cpu_muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, A, B, input busy, done, hi, lo);
    modport slave  (input start, op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_divider.sv
// Restoring unsigned divider: one quotient bit per cycle over ITER_COUNT cycles.
// Operands are magnitudes; sign handling is done by the caller.
module mips_cpu_divider
    import mips_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      quo;
    logic [31:0]      rem;
    logic [31:0]      dvs;
    logic [32:0]      rem_sh;
    logic             fits;

    // Dividend bits shift out of quo into rem while quotient bits shift in.
    assign rem_sh = {rem, quo[31]};
    assign fits   = rem_sh >= {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CNT_W'(ITER_COUNT - 1);
            quo     <= dividend;
            rem     <= '0;
            dvs     <= divisor;
        end else if (running) begin
            if (fits) begin
                rem <= rem_sh[31:0] - dvs;
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= rem_sh[31:0];
                quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
                running <= 1'b0;
            end
        end
    end

    assign done      = running && (cnt == '0);
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply-divide unit. Define MIPS_CPU_MULDIV_FAST_MULT_EN for a
// single-cycle combinational multiplier; otherwise multiply is 32-step shift-add.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mips_cpu_muldiv_if.slave  bus
);

    // state | meaning
    // IDLE  | waiting for a request; MTHI/MTLO complete here
    // CALC  | one multiply/divide iteration per cycle
    // FIXUP | sign correction; HI/LO written at the exit edge
    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_e;

    state_e           state, state_nxt;
    op_e              op_q;
    logic [31:0]      a_q, b_q, hi_q, lo_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt;
    logic             accept, is_mul_req, is_div_req;
    logic             signed_q, is_div_q;
    logic             div_start, div_done;
    logic [31:0]      div_quo, div_rem;
    logic [63:0]      mul_full;
    logic [31:0]      res_hi, res_lo;

    assign accept     = bus.start && (state == IDLE);
    assign is_mul_req = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign is_div_req = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign signed_q   = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign is_div_q   = (op_q == OP_DIV)  || (op_q == OP_DIVU);
    assign div_start  = accept && is_div_req;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
                    if (is_mul_req)      state_nxt = FIXUP;
                    else if (is_div_req) state_nxt = CALC;
`else
                    if (is_mul_req || is_div_req) state_nxt = CALC;
`endif
                end
            end
            CALC:    if (is_div_q ? div_done : (cnt == '0)) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mips_cpu_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (magnitude(bus.A, bus.op == OP_DIV)),
        .divisor   (magnitude(bus.B, bus.op == OP_DIV)),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    logic [63:0] ext_a, ext_b;
    // Sign-extending to 64 bits lets one unsigned multiply serve both MULT and MULTU.
    assign ext_a = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign ext_b = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
`else
    logic [63:0] prod;
    logic [32:0] prod_sum;

    assign prod_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, magnitude(a_q, signed_q)} : 33'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
        end else if (accept && is_mul_req) begin
            prod <= {32'd0, magnitude(bus.B, bus.op == OP_MULT)};
        end else if ((state == CALC) && !is_div_q) begin
            prod <= {prod_sum, prod[31:1]};
        end
    end
`endif

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
        mul_full = ext_a * ext_b;
`else
        mul_full = (signed_q && (a_q[31] ^ b_q[31])) ? (~prod + 64'd1) : prod;
`endif
        if (is_div_q) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_lo = (signed_q && (a_q[31] ^ b_q[31])) ? (~div_quo + 32'd1) : div_quo;
                res_hi = (signed_q && a_q[31]) ? (~div_rem + 32'd1) : div_rem;
            end
        end else begin
            res_hi = mul_full[63:32];
            res_lo = mul_full[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (bus.op == OP_MTHI) begin
                    hi_q <= bus.A;
                end else if (bus.op == OP_MTLO) begin
                    lo_q <= bus.A;
                end else if (is_mul_req || is_div_req) begin
                    op_q <= op_e'(bus.op);
                    a_q  <= bus.A;
                    b_q  <= bus.B;
                    cnt  <= CNT_W'(ITER_COUNT - 1);
                end
            end
            if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == FIXUP) begin
                hi_q   <= res_hi;
                lo_q   <= res_lo;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed vector table, corner-case
// sequences, and random operations against a plain-arithmetic reference model.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    mips_cpu_muldiv_if bus();

    mips_cpu_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        eh = 'x;
        el = 'x;
        case (op)
            OP_MULT:  begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
            OP_MULTU: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
            OP_DIV: begin
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0]; end
            end
            OP_DIVU: begin
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin uq = ua / ub; ur = ua % ub; eh = ur[31:0]; el = uq[31:0]; end
            end
            default: ;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] h0, l0;
        int          n, lat;
        bit          held_ok, early_done;
        lat = (op == OP_MULT || op == OP_MULTU) ? MUL_LAT : DIV_LAT;
        h0 = bus.hi;
        l0 = bus.lo;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        n = 0;
        held_ok = 1'b1;
        early_done = 1'b0;
        while (bus.busy && n < 200) begin
            n++;
            if (bus.hi !== h0 || bus.lo !== l0) held_ok = 1'b0;
            if (bus.done !== 1'b0) early_done = 1'b1;
            tick();
        end
        check({name, " busy_cycles"}, n, lat);
        check({name, " hilo_held"}, held_ok, 1);
        check({name, " done_during_busy"}, early_done, 0);
        check({name, " done"}, bus.done, 1);
        check({name, " hi"}, bus.hi, eh);
        check({name, " lo"}, bus.lo, el);
        tick();
        check({name, " done_pulse_end"}, bus.done, 0);
    endtask

    initial begin
        logic [31:0] eh, el, a, b;
        logic [2:0]  op;
        int          busy_n, done_n;
        logic [31:0] hi_at_done, lo_at_done;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.A = 32'h1111_1111;
        bus.B = 32'h2222_2222;
        tick();
        tick();
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);
        end

        // MTHI then MTLO back to back
        bus.start = 1'b1;
        bus.op = OP_MTHI;
        bus.A = 32'h1234_5678;
        tick();
        check("mthi hi", bus.hi, 32'h1234_5678);
        check("mthi busy", bus.busy, 0);
        check("mthi done", bus.done, 0);
        bus.op = OP_MTLO;
        bus.A = 32'h9ABC_DEF0;
        tick();
        bus.start = 1'b0;
        check("mtlo lo", bus.lo, 32'h9ABC_DEF0);
        check("mtlo hi_kept", bus.hi, 32'h1234_5678);
        check("mtlo busy", bus.busy, 0);
        check("mtlo done", bus.done, 0);

        // second start while a divide is running is dropped
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.A = 32'd100;
        bus.B = 32'd7;
        tick();
        bus.start = 1'b0;
        busy_n = 0;
        done_n = 0;
        hi_at_done = '0;
        lo_at_done = '0;
        for (int i = 0; i < 60; i++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                hi_at_done = bus.hi;
                lo_at_done = bus.lo;
            end
            if (i >= 3 && i <= 5) begin
                bus.start = 1'b1;
                bus.op = OP_MULT;
                bus.A = 32'd5;
                bus.B = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        check("restart busy_cycles", busy_n, 33);
        check("restart done_count", done_n, 1);
        check("restart hi", hi_at_done, 32'd2);
        check("restart lo", lo_at_done, 32'd14);

        // reset at busy cycle 10 aborts without writeback
        bus.start = 1'b1;
        bus.op = OP_DIVU;
        bus.A = 32'd1000;
        bus.B = 32'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("abort busy_before", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort hi", bus.hi, 0);
        check("abort lo", bus.lo, 0);
        check("abort done", bus.done, 0);
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_n++;
            if (bus.busy) busy_n++;
            tick();
        end
        check("abort no_done", done_n, 0);
        check("abort no_busy", busy_n, 0);
        check("abort hilo", {bus.hi, bus.lo}, 64'd0);

        // reset wins over a simultaneous start
        reset = 1'b1;
        bus.start = 1'b1;
        bus.op = OP_MTHI;
        bus.A = 32'hDEAD_BEEF;
        tick();
        check("rst_prio mthi", bus.hi, 0);
        bus.op = OP_DIV;
        tick();
        check("rst_prio div_busy", bus.busy, 0);
        reset = 1'b0;
        bus.start = 1'b0;
        tick();

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            model(op, a, b, eh, el);
            run_op($sformatf("rand%0d", i), op, a, b, eh, el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
